// File: rtl/board_anim_pkg.sv
// Shared types and constants for the board token animation sequencer.
package board_anim_pkg;

  localparam int POS_W = 4;

  localparam logic [POS_W-1:0] EVENT_NONE = 4'd0;
  localparam logic [POS_W-1:0] EVENT_WIN  = 4'd10;

  typedef enum logic [2:0] {
    IDLE,
    WALK,
    DONE,
    POST,
    EVENT_DWELL
  } anim_state_t;

  // Limit a controller position to the last square of the board.
  function automatic logic [POS_W-1:0] clampPos(input logic [POS_W-1:0] pos,
                                                input logic [POS_W-1:0] maxPos);
    return (pos > maxPos) ? maxPos : pos;
  endfunction

endpackage

// File: rtl/anim_tick_timer.sv
// Free-running period timer shared by the step and event-dwell phases.
// i_last is the final count value (period - 1); o_tick marks that cycle.
module anim_tick_timer #(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clear,
  input  logic             i_enable,
  input  logic [CNT_W-1:0] i_last,
  output logic             o_tick
);

  logic [CNT_W-1:0] r_count;

  assign o_tick = i_enable && (r_count == i_last);

  // Count enabled cycles, wrapping to zero on the terminal cycle or a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear || o_tick) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/board_anim_sequencer.sv
// Walks player tokens one square per step period between the game
// controller and the board renderer, dwelling on event squares and
// pulsing turn_done when each animation is finished.
module board_anim_sequencer
  import board_anim_pkg::*;
#(
  parameter int STEP_TICKS  = 25_000_000,
  parameter int EVENT_TICKS = 50_000_000,
  parameter int MAX_POS     = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pos_valid,
  input  logic [3:0] p1_pos,
  input  logic [3:0] p2_pos,
  input  logic       turn,
  input  logic [3:0] event_flag,
  input  logic       winner_valid,
  output logic [3:0] disp_p1_pos,
  output logic [3:0] disp_p2_pos,
  output logic       anim_player,
  output logic       moving,
  output logic       step_strobe,
  output logic       turn_done
);

  localparam int MAX_TICKS = (STEP_TICKS > EVENT_TICKS) ? STEP_TICKS : EVENT_TICKS;
  localparam int CNT_W     = $clog2(MAX_TICKS);

  localparam logic [CNT_W-1:0] STEP_LAST  = CNT_W'(STEP_TICKS - 1);
  localparam logic [CNT_W-1:0] EVENT_LAST = CNT_W'(EVENT_TICKS - 1);
  localparam logic [POS_W-1:0] MAX_POS_L  = POS_W'(MAX_POS);

  anim_state_t      r_state;
  logic             r_pos_valid_q;
  logic             r_second_pass;
  logic             r_post_second;
  logic [POS_W-1:0] r_target;
  logic [POS_W-1:0] r_disp_p1;
  logic [POS_W-1:0] r_disp_p2;
  logic             r_anim_player;
  logic             r_moving;
  logic             r_step_strobe;
  logic             r_turn_done;

  logic             w_start;
  logic [POS_W-1:0] w_cur_pos;
  logic             w_at_target;
  logic [POS_W-1:0] w_next_pos;
  logic [POS_W-1:0] w_start_target;
  logic [POS_W-1:0] w_event_target;
  logic             w_timer_clear;
  logic             w_timer_enable;
  logic [CNT_W-1:0] w_timer_last;
  logic             w_tick;

  assign w_start        = pos_valid & ~r_pos_valid_q;
  assign w_cur_pos      = r_anim_player ? r_disp_p2 : r_disp_p1;
  assign w_at_target    = (w_cur_pos == r_target);
  assign w_next_pos     = (r_target > w_cur_pos) ? (w_cur_pos + POS_W'(1))
                                                 : (w_cur_pos - POS_W'(1));
  assign w_start_target = clampPos(turn ? p2_pos : p1_pos, MAX_POS_L);
  assign w_event_target = clampPos(r_anim_player ? p2_pos : p1_pos, MAX_POS_L);

  // The timer only runs while walking toward a target or dwelling; every
  // other state holds it at zero so each phase starts from a fresh period.
  assign w_timer_clear  = (r_state != WALK) && (r_state != EVENT_DWELL);
  assign w_timer_enable = ((r_state == WALK) && !w_at_target) || (r_state == EVENT_DWELL);
  assign w_timer_last   = (r_state == EVENT_DWELL) ? EVENT_LAST : STEP_LAST;

  anim_tick_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .i_clear  (w_timer_clear),
    .i_enable (w_timer_enable),
    .i_last   (w_timer_last),
    .o_tick   (w_tick)
  );

  // Delayed copy of pos_valid for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pos_valid_q <= 1'b0;
    end else begin
      r_pos_valid_q <= pos_valid;
    end
  end

  // Animation FSM with registered display positions and pulse outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_second_pass <= 1'b0;
      r_post_second <= 1'b0;
      r_target      <= '0;
      r_disp_p1     <= '0;
      r_disp_p2     <= '0;
      r_anim_player <= 1'b0;
      r_moving      <= 1'b0;
      r_step_strobe <= 1'b0;
      r_turn_done   <= 1'b0;
    end else begin
      r_step_strobe <= 1'b0;
      r_turn_done   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_anim_player <= turn;
            r_target      <= w_start_target;
            r_second_pass <= 1'b0;
            r_moving      <= 1'b1;
            r_state       <= WALK;
          end
        end
        WALK: begin
          if (w_at_target) begin
            r_turn_done <= 1'b1;
            r_moving    <= 1'b0;
            r_state     <= DONE;
          end else if (w_tick) begin
            r_step_strobe <= 1'b1;
            if (r_anim_player) begin
              r_disp_p2 <= w_next_pos;
            end else begin
              r_disp_p1 <= w_next_pos;
            end
          end
        end
        DONE: begin
          r_post_second <= 1'b0;
          r_state       <= r_second_pass ? IDLE : POST;
        end
        POST: begin
          if (!r_post_second) begin
            r_post_second <= 1'b1;
          end else if (winner_valid || (event_flag == EVENT_NONE) ||
                       (event_flag == EVENT_WIN)) begin
            r_state <= IDLE;
          end else begin
            r_target      <= w_event_target;
            r_second_pass <= 1'b1;
            r_moving      <= 1'b1;
            r_state       <= EVENT_DWELL;
          end
        end
        EVENT_DWELL: begin
          if (w_tick) begin
            r_state <= WALK;
          end
        end
        default: begin
          r_moving <= 1'b0;
          r_state  <= IDLE;
        end
      endcase
    end
  end

  assign disp_p1_pos = r_disp_p1;
  assign disp_p2_pos = r_disp_p2;
  assign anim_player = r_anim_player;
  assign moving      = r_moving;
  assign step_strobe = r_step_strobe;
  assign turn_done   = r_turn_done;

endmodule
